// File: rtl/demux_2_for_32_bits_buffered_pkg.sv
// demux_2_for_32_bits_buffered_pkg: channel ids, default sizes and FIFO occupancy states
package demux_2_for_32_bits_buffered_pkg;
   localparam logic CH0 = 1'b0;
   localparam logic CH1 = 1'b1;
   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 2;
   localparam int DEF_CNTW = 16;
   typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_state_e;
endpackage

// File: rtl/demux_2_for_32_bits_buffered_chan_fifo.sv
// demux_chan_fifo: per-channel FIFO with pointers, occupancy and zeroed-when-empty head output
module demux_chan_fifo
   import demux_2_for_32_bits_buffered_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head_data
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] occ, occ_nx;
   logic push_ok, pop_ok;
   occ_state_e state;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push_ok);
         rd_ptr <= rd_ptr + AW'(pop_ok);
         occ <= occ_nx;
      end
   end
   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end
   // a full FIFO refuses pushes even when a pop happens on the same edge
   always_comb begin
      push_ok = push & ~full;
      pop_ok = pop & ~empty;
      occ_nx = occ + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   end
   always_comb begin
      state = (occ == '0) ? EMPTY : (occ == (AW+1)'(DEPTH)) ? FULL : PARTIAL;
      full = (state == FULL);
      empty = (state == EMPTY);
      head_data = empty ? '0 : mem[rd_ptr];
   end
endmodule

// File: rtl/demux_2_for_32_bits_buffered.sv
// demux_2_for_32_bits_buffered: routes one valid/ready stream to two buffered channels
// Optional per-channel pop counters are enabled with STATS_EN.
module demux_2_for_32_bits_buffered
   import demux_2_for_32_bits_buffered_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
`ifdef STATS_EN
   , parameter int CNTW = DEF_CNTW
`endif
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_select,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data
`ifdef STATS_EN
   , output logic [CNTW-1:0] out0_count,
   output logic [CNTW-1:0] out1_count
`endif
);
   logic full0, full1, empty0, empty1, push0, push1, pop0, pop1;
   // in_ready depends only on FIFO state and in_select, never on the consumer readies
   always_comb begin
      in_ready = (in_select == CH1) ? ~full1 : ~full0;
      push0 = in_valid & in_ready & (in_select == CH0);
      push1 = in_valid & in_ready & (in_select == CH1);
      out0_valid = ~empty0;
      out1_valid = ~empty1;
      pop0 = out0_valid & out0_ready;
      pop1 = out1_valid & out1_ready;
   end
   demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch0 (
      .clock(clock), .reset(reset), .push(push0), .push_data(in_data), .pop(pop0),
      .full(full0), .empty(empty0), .head_data(out0_data)
   );
   demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ch1 (
      .clock(clock), .reset(reset), .push(push1), .push_data(in_data), .pop(pop1),
      .full(full1), .empty(empty1), .head_data(out1_data)
   );
`ifdef STATS_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out0_count <= '0;
         out1_count <= '0;
      end else begin
         if (pop0) out0_count <= out0_count + CNTW'(1);
         if (pop1) out1_count <= out1_count + CNTW'(1);
      end
   end
`endif
endmodule

// File: tb/tb_demux_2_for_32_bits_buffered.sv
// tb_demux_2_for_32_bits_buffered: vector table, corner sequences and queue-model random test
module tb_demux_2_for_32_bits_buffered;
   localparam int DEPTH = 2;
   logic clock, reset, in_valid, in_select, in_ready;
   logic [31:0] in_data, out0_data, out1_data;
   logic out0_valid, out0_ready, out1_valid, out1_ready;
   int checks = 0;
   int failures = 0;
`ifdef STATS_EN
   logic [3:0] out0_count, out1_count;
`endif

   demux_2_for_32_bits_buffered #(.WIDTH(32), .DEPTH(DEPTH)
`ifdef STATS_EN
      , .CNTW(4)
`endif
   ) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_select(in_select),
      .in_data(in_data), .in_ready(in_ready),
      .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
      .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data)
`ifdef STATS_EN
      , .out0_count(out0_count), .out1_count(out1_count)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic iv, sel;
      logic [31:0] d;
      logic r0, r1, ir, v0;
      logic [31:0] d0;
      logic v1;
      logic [31:0] d1;
   } vec_t;
   vec_t tbl[11];

   logic [31:0] q0[$], q1[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic sel, input logic [31:0] d, input logic r0, input logic r1);
      in_valid = iv;
      in_select = sel;
      in_data = d;
      out0_ready = r0;
      out1_ready = r1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      q0.delete();
      q1.delete();
   endtask

   initial begin
      logic ir_exp, acc, p0, p1;
      int n0, n1;
      tbl[0]  = '{1, 0, 32'hA5A5A5A5, 1, 1, 1, 1, 32'hA5A5A5A5, 0, 0};
      tbl[1]  = '{1, 1, 32'h5A5A5A5A, 1, 1, 1, 0, 0, 1, 32'h5A5A5A5A};
      tbl[2]  = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
      tbl[3]  = '{1, 0, 1, 0, 1, 1, 1, 1, 0, 0};
      tbl[4]  = '{1, 0, 2, 0, 1, 1, 1, 1, 0, 0};
      tbl[5]  = '{1, 0, 3, 0, 1, 0, 1, 1, 0, 0};
      tbl[6]  = '{1, 1, 32'h77, 0, 0, 1, 1, 1, 1, 32'h77};
      tbl[7]  = '{1, 0, 3, 1, 0, 0, 1, 2, 1, 32'h77};
      tbl[8]  = '{1, 0, 3, 0, 0, 1, 1, 2, 1, 32'h77};
      tbl[9]  = '{0, 0, 0, 1, 0, 0, 1, 3, 1, 32'h77};
      tbl[10] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0};

      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      #2;
      chk("rst_v0", 32'(out0_valid), 0);
      chk("rst_v1", 32'(out1_valid), 0);
      chk("rst_d0", out0_data, 0);
      chk("rst_d1", out1_data, 0);
      chk("rst_ir", 32'(in_ready), 1);
`ifdef STATS_EN
      chk("rst_c0", 32'(out0_count), 0);
      chk("rst_c1", 32'(out1_count), 0);
`endif
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].iv, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
         #1;
         chk($sformatf("vec%0d_ir", i), 32'(in_ready), 32'(tbl[i].ir));
         tick();
         chk($sformatf("vec%0d_v0", i), 32'(out0_valid), 32'(tbl[i].v0));
         chk($sformatf("vec%0d_d0", i), out0_data, tbl[i].d0);
         chk($sformatf("vec%0d_v1", i), 32'(out1_valid), 32'(tbl[i].v1));
         chk($sformatf("vec%0d_d1", i), out1_data, tbl[i].d1);
      end

      // channel 1 holds one word while pushing and popping every edge
      drive(1, 1, 100, 0, 0);
      tick();
      for (int k = 0; k < 20; k++) begin
         drive(1, 1, 32'(101 + k), 0, 1);
         #1;
         chk("pp_ir", 32'(in_ready), 1);
         chk("pp_head", out1_data, 32'(100 + k));
         tick();
         chk("pp_v1", 32'(out1_valid), 1);
         chk("pp_d1", out1_data, 32'(101 + k));
      end
      drive(0, 1, 0, 0, 1);
      tick();
      chk("pp_drain", 32'(out1_valid), 0);

      // asynchronous reset with both FIFOs full
      drive(1, 0, 32'h11, 0, 0); tick();
      drive(1, 0, 32'h12, 0, 0); tick();
      drive(1, 1, 32'h21, 0, 0); tick();
      drive(1, 1, 32'h22, 0, 0); tick();
      chk("full_ir", 32'(in_ready), 0);
      drive(0, 0, 0, 1, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_v0", 32'(out0_valid), 0);
      chk("arst_v1", 32'(out1_valid), 0);
      chk("arst_ir", 32'(in_ready), 1);
      @(negedge clock);
      reset = 1'b0;
      repeat (3) begin
         tick();
         chk("post_v0", 32'(out0_valid), 0);
         chk("post_v1", 32'(out1_valid), 0);
         chk("post_d0", out0_data, 0);
      end

      do_reset();
      n0 = 0;
      n1 = 0;
      for (int i = 0; i < 400; i++) begin
         drive(($urandom % 4) != 0, 1'($urandom), $urandom, ($urandom % 3) != 0, ($urandom % 3) != 0);
         #1;
         ir_exp = in_select ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
         chk("rnd_ir", 32'(in_ready), 32'(ir_exp));
         acc = in_valid & ir_exp;
         p0 = (q0.size() > 0) & out0_ready;
         p1 = (q1.size() > 0) & out1_ready;
         tick();
         if (p0) begin void'(q0.pop_front()); n0++; end
         if (p1) begin void'(q1.pop_front()); n1++; end
         if (acc) begin
            if (in_select) q1.push_back(in_data);
            else q0.push_back(in_data);
         end
         chk("rnd_v0", 32'(out0_valid), 32'(q0.size() > 0));
         chk("rnd_d0", out0_data, q0.size() > 0 ? q0[0] : 32'h0);
         chk("rnd_v1", 32'(out1_valid), 32'(q1.size() > 0));
         chk("rnd_d1", out1_data, q1.size() > 0 ? q1[0] : 32'h0);
`ifdef STATS_EN
         chk("rnd_c0", 32'(out0_count), 32'(n0 % 16));
         chk("rnd_c1", 32'(out1_count), 32'(n1 % 16));
`endif
      end

`ifdef STATS_EN
      do_reset();
      for (int k = 0; k < 17; k++) begin
         drive(1, 0, 32'(k), 0, 0); tick();
         drive(0, 0, 0, 1, 0); tick();
      end
      chk("wrap_c0", 32'(out0_count), 1);
      chk("wrap_c1", 32'(out1_count), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
